// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour core: FSM encoding,
// drain length and a constant-foldable ceil(log2) helper.
package knn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } knn_state_t;

    // Cycles spent after the last handshake so the distance and insert
    // stages can retire the final point before DONE is raised.
    localparam int DRAIN_CYCLES = 2;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/knn_insert_list.sv
// K-entry sorted list of (distance, index) pairs, ascending by distance.
// One insertion per cycle; equal distances keep the earlier arrival first.
module knn_insert_list
    import knn_pkg::*;
#(
    parameter int K      = 6,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     ins_valid,
    input  logic [DATA_W-1:0]        ins_dist,
    input  logic [IDX_W-1:0]         ins_idx,
    output logic [K*DATA_W-1:0]      list_dist,
    output logic [K*IDX_W-1:0]       list_idx,
    output logic [clog2(K+1)-1:0]    fill
);

    localparam int FILL_W = clog2(K + 1);

    logic [K-1:0][DATA_W-1:0] dist_reg;
    logic [K-1:0][DATA_W-1:0] dist_next;
    logic [K-1:0][IDX_W-1:0]  idx_reg;
    logic [K-1:0][IDX_W-1:0]  idx_next;
    logic [FILL_W-1:0]        fill_reg;
    logic [FILL_W-1:0]        fill_next;

    // gt[i]: the new entry belongs at or before slot i. Empty slots always
    // qualify, so an all-ones distance can still land in an unused slot.
    logic [K-1:0]             gt;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_entry
            logic              shift_in;
            logic [DATA_W-1:0] prev_dist;
            logic [IDX_W-1:0]  prev_idx;

            if (gi == 0) begin : g_head
                assign shift_in  = 1'b0;
                assign prev_dist = '1;
                assign prev_idx  = '0;
            end else begin : g_body
                assign shift_in  = gt[gi-1];
                assign prev_dist = dist_reg[gi-1];
                assign prev_idx  = idx_reg[gi-1];
            end

            assign gt[gi] = (gi >= int'(fill_reg)) || (dist_reg[gi] > ins_dist);

            // Slot takes the new entry where gt first rises, otherwise
            // shifts its upper neighbour down once the insertion point is above.
            assign dist_next[gi] = (ins_valid && gt[gi])
                                 ? (shift_in ? prev_dist : ins_dist)
                                 : dist_reg[gi];
            assign idx_next[gi]  = (ins_valid && gt[gi])
                                 ? (shift_in ? prev_idx : ins_idx)
                                 : idx_reg[gi];
        end
    endgenerate

    assign fill_next = (ins_valid && (int'(fill_reg) < K)) ? fill_reg + 1'b1 : fill_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_reg <= '1;
            idx_reg  <= '0;
            fill_reg <= '0;
        end else if (clear) begin
            dist_reg <= '1;
            idx_reg  <= '0;
            fill_reg <= '0;
        end else begin
            dist_reg <= dist_next;
            idx_reg  <= idx_next;
            fill_reg <= fill_next;
        end
    end

    assign list_dist = dist_reg;
    assign list_idx  = idx_reg;
    assign fill      = fill_reg;

endmodule

// File: rtl/knn_core_param.sv
// Streaming k-nearest-neighbour core: accepts data points, computes the
// absolute distance to a latched test point and keeps the K closest.
module knn_core_param
    import knn_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int K      = 6,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     knn_start,
    input  logic [DATA_W-1:0]        knn_test_pt,
    input  logic                     knn_dp_valid,
    input  logic [DATA_W-1:0]        knn_dp,
    input  logic                     knn_dp_last,
    output logic                     knn_dp_ready,
    output logic [K*DATA_W-1:0]      knn_dist_out,
    output logic [K*IDX_W-1:0]       knn_idx_out,
    output logic [clog2(K+1)-1:0]    knn_fill,
    output logic                     knn_done,
    output logic                     knn_ovf
);

    localparam int DRAIN_W = clog2(DRAIN_CYCLES + 1);

    knn_state_t          state_reg;
    logic [DATA_W-1:0]   test_pt_reg;
    logic [IDX_W-1:0]    idx_cnt_reg;
    logic                wrap_reg;
    logic                ovf_reg;
    logic                ready_reg;
    logic                done_reg;
    logic [DRAIN_W-1:0]  drain_cnt_reg;

    logic                s1_valid_reg;
    logic [DATA_W-1:0]   s1_dist_reg;
    logic [IDX_W-1:0]    s1_idx_reg;

    logic                accept;
    logic                list_clear;
    logic [DATA_W-1:0]   dp_dist;

    // ready_reg is only ever high in RUN, so it doubles as the state qualifier.
    assign accept     = knn_dp_valid && ready_reg;
    assign list_clear = knn_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign dp_dist    = (knn_dp >= test_pt_reg) ? (knn_dp - test_pt_reg)
                                                : (test_pt_reg - knn_dp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            test_pt_reg   <= '0;
            idx_cnt_reg   <= '0;
            wrap_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
            drain_cnt_reg <= '0;
            s1_valid_reg  <= 1'b0;
            s1_dist_reg   <= '0;
            s1_idx_reg    <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_dist_reg <= dp_dist;
                s1_idx_reg  <= idx_cnt_reg;
                idx_cnt_reg <= idx_cnt_reg + 1'b1;
                // wrap_reg marks that every later point carries a reused index.
                if (&idx_cnt_reg) begin
                    wrap_reg <= 1'b1;
                end
                if (wrap_reg) begin
                    ovf_reg <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (knn_start) begin
                        test_pt_reg <= knn_test_pt;
                        idx_cnt_reg <= '0;
                        wrap_reg    <= 1'b0;
                        ovf_reg     <= 1'b0;
                        done_reg    <= 1'b0;
                        ready_reg   <= 1'b1;
                        state_reg   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && knn_dp_last) begin
                        ready_reg     <= 1'b0;
                        drain_cnt_reg <= '0;
                        state_reg     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    knn_insert_list #(
        .K      (K),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_list (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (list_clear),
        .ins_valid (s1_valid_reg),
        .ins_dist  (s1_dist_reg),
        .ins_idx   (s1_idx_reg),
        .list_dist (knn_dist_out),
        .list_idx  (knn_idx_out),
        .fill      (knn_fill)
    );

    assign knn_dp_ready = ready_reg;
    assign knn_done     = done_reg;
    assign knn_ovf      = ovf_reg;

endmodule

// File: tb/tb_knn_core_param.sv
// Randomised self-checking bench for knn_core_param against a
// selection-based reference of the K nearest points.
module tb_knn_core_param;

    localparam int K      = 6;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 8;
    localparam int FILL_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  knn_start = 1'b0;
    logic [DATA_W-1:0]     knn_test_pt = '0;
    logic                  knn_dp_valid = 1'b0;
    logic [DATA_W-1:0]     knn_dp = '0;
    logic                  knn_dp_last = 1'b0;
    logic                  knn_dp_ready;
    logic [K*DATA_W-1:0]   knn_dist_out;
    logic [K*IDX_W-1:0]    knn_idx_out;
    logic [FILL_W-1:0]     knn_fill;
    logic                  knn_done;
    logic                  knn_ovf;

    knn_core_param #(
        .DATA_W (DATA_W),
        .K      (K),
        .IDX_W  (IDX_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .knn_start    (knn_start),
        .knn_test_pt  (knn_test_pt),
        .knn_dp_valid (knn_dp_valid),
        .knn_dp       (knn_dp),
        .knn_dp_last  (knn_dp_last),
        .knn_dp_ready (knn_dp_ready),
        .knn_dist_out (knn_dist_out),
        .knn_idx_out  (knn_idx_out),
        .knn_fill     (knn_fill),
        .knn_done     (knn_done),
        .knn_ovf      (knn_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] q_pts[$];
    logic [DATA_W-1:0] exp_dist[K];
    logic [IDX_W-1:0]  exp_idx[K];
    int                exp_fill;
    logic              exp_ovf;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference: repeatedly pick the closest unused point, earliest wins ties.
    task automatic build_expect(input logic [DATA_W-1:0] tp);
        int n;
        bit used[];
        n = q_pts.size();
        used = new[n];
        for (int s = 0; s < K; s++) begin
            int best;
            logic [DATA_W-1:0] best_d;
            best = -1;
            best_d = '1;
            for (int j = 0; j < n; j++) begin
                if (!used[j]) begin
                    logic [DATA_W-1:0] d;
                    d = abs_diff(q_pts[j], tp);
                    if (best < 0 || d < best_d) begin
                        best = j;
                        best_d = d;
                    end
                end
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                exp_dist[s] = best_d;
                exp_idx[s] = IDX_W'(best % (1 << IDX_W));
            end else begin
                exp_dist[s] = '1;
                exp_idx[s] = '0;
            end
        end
        exp_fill = (n < K) ? n : K;
        exp_ovf = (n > (1 << IDX_W));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".ready"}, knn_dp_ready, 0);
        check_eq({tag, ".done"}, knn_done, 0);
        check_eq({tag, ".ovf"}, knn_ovf, 0);
        check_eq({tag, ".fill"}, knn_fill, 0);
        for (int e = 0; e < K; e++) begin
            check_eq($sformatf("%s.dist%0d", tag, e), knn_dist_out[e*DATA_W +: DATA_W], {DATA_W{1'b1}});
            check_eq($sformatf("%s.idx%0d", tag, e), knn_idx_out[e*IDX_W +: IDX_W], 0);
        end
    endtask

    task automatic compare_results(input string tag);
        check_eq({tag, ".fill"}, knn_fill, exp_fill);
        check_eq({tag, ".ovf"}, knn_ovf, exp_ovf);
        check_eq({tag, ".ready"}, knn_dp_ready, 0);
        for (int e = 0; e < K; e++) begin
            check_eq($sformatf("%s.dist%0d", tag, e), knn_dist_out[e*DATA_W +: DATA_W], exp_dist[e]);
            check_eq($sformatf("%s.idx%0d", tag, e), knn_idx_out[e*IDX_W +: IDX_W], exp_idx[e]);
        end
    endtask

    task automatic start_query(input logic [DATA_W-1:0] tp);
        knn_start = 1'b1;
        knn_test_pt = tp;
        step();
        knn_start = 1'b0;
        knn_test_pt = $urandom;
    endtask

    task automatic send_point(input logic [DATA_W-1:0] dp, input bit last);
        int waited;
        waited = 0;
        knn_dp = dp;
        knn_dp_last = last;
        knn_dp_valid = 1'b1;
        while (!knn_dp_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!knn_dp_ready) begin
            check_eq("ready_timeout", knn_dp_ready, 1);
        end
        step();
        knn_dp_valid = 1'b0;
        knn_dp_last = 1'b0;
    endtask

    task automatic run_query(input string name, input logic [DATA_W-1:0] tp,
                             input int gap_max, input int inject_at);
        int n;
        int lat;
        n = q_pts.size();
        start_query(tp);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) step();
            end
            if (i == inject_at) begin
                knn_start = 1'b1;
                knn_test_pt = '0;
                step();
                knn_start = 1'b0;
            end
            send_point(q_pts[i], i == n - 1);
        end
        check_eq({name, ".done_early"}, knn_done, 0);
        lat = 0;
        while (!knn_done && lat < 20) begin
            step();
            lat++;
        end
        check_eq({name, ".done_lat"}, lat, 2);
        build_expect(tp);
        compare_results(name);
        // Points offered while DONE must not disturb the final list.
        for (int c = 0; c < 3; c++) begin
            knn_dp_valid = 1'b1;
            knn_dp = $urandom;
            step();
        end
        knn_dp_valid = 1'b0;
        check_eq({name, ".done_hold"}, knn_done, 1);
        compare_results({name, "_hold"});
        $display("query %-12s tp=%0d n=%0d fill=%0d ovf=%0d done_lat=%0d",
                 name, tp, n, knn_fill, knn_ovf, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        rst_n = 1'b1;
        step();

        // Without a START the core must not accept anything.
        knn_dp_valid = 1'b1;
        knn_dp = 32'd5;
        repeat (3) begin
            step();
            check_eq("no_start.ready", knn_dp_ready, 0);
        end
        knn_dp_valid = 1'b0;
        check_eq("no_start.fill", knn_fill, 0);

        q_pts = '{32'd90, 32'd105, 32'd130, 32'd99, 32'd100, 32'd250, 32'd0, 32'd101};
        run_query("basic", 32'd100, 0, -1);

        q_pts = '{32'd7, 32'd9, 32'd3};
        run_query("underfill", 32'd7, 0, -1);

        q_pts = '{32'd90, 32'd105, 32'd130, 32'd99, 32'd100, 32'd250, 32'd0, 32'd101};
        for (int r = 0; r < 3; r++) begin
            run_query($sformatf("gaps%0d", r), 32'd100, 3, -1);
        end

        run_query("start_ign", 32'd100, 1, 3);

        // Reset in the middle of a query, while stage 1 holds a point.
        start_query(32'd7);
        send_point(32'd50, 1'b0);
        send_point(32'd60, 1'b0);
        send_point(32'd70, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        step();
        rst_n = 1'b1;
        step();
        check_reset_state("midrst_rel");
        q_pts = '{32'd7, 32'd9, 32'd3};
        run_query("after_rst", 32'd7, 0, -1);

        q_pts = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF};
        run_query("all_ones", 32'd0, 1, -1);

        q_pts.delete();
        for (int i = 0; i < 256; i++) q_pts.push_back(32'($urandom_range(0, 1000)));
        run_query("n256", 32'd500, 0, -1);

        q_pts.delete();
        for (int i = 0; i < 257; i++) q_pts.push_back(32'd55);
        run_query("ovf257", 32'd55, 0, -1);

        for (int r = 0; r < 8; r++) begin
            int n;
            logic [DATA_W-1:0] tp;
            n = $urandom_range(1, 20);
            tp = 32'($urandom_range(0, 50));
            q_pts.delete();
            for (int i = 0; i < n; i++) q_pts.push_back(32'($urandom_range(0, 100)));
            run_query($sformatf("rand%0d", r), tp, 2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/knn_core_param.md
KNN_CORE_PARAM -- requirements
Module: knn_core_param

Interface
REQ-001 Parameter DATA_W, default 32: width of the test point, the data points and the distances.
REQ-002 Parameter K, default 6, range 1..16: number of nearest neighbours kept.
REQ-003 Parameter IDX_W, default 8: width of the data-point index; at most 2^IDX_W points per query.
REQ-004 CLK_CORE  in  1  single clock; all logic is on the rising edge.
REQ-005 RST_CORE  in  1  reset; asynchronous, active-low.
REQ-006 KNN_START  in  1  pulse; latches the test point and begins a query.
REQ-007 KNN_TEST_PT  in  DATA_W  unsigned test point, sampled with KNN_START.
REQ-008 KNN_DP_VALID  in  1  data-point valid.
REQ-009 KNN_DP  in  DATA_W  unsigned data point.
REQ-010 KNN_DP_LAST  in  1  marks the final data point of the query.
REQ-011 KNN_DP_READY  out  1  core accepts a data point.
REQ-012 KNN_DIST_OUT  out  K*DATA_W  sorted distances; entry 0 occupies the LSBs.
REQ-013 KNN_IDX_OUT  out  K*IDX_W  index of each entry.
REQ-014 KNN_FILL  out  clog2(K+1)  number of valid entries.
REQ-015 KNN_DONE  out  1  level signal; the results are final.
REQ-016 KNN_OVF  out  1  sticky flag; more than 2^IDX_W points were offered.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-018 In IDLE or DONE, KNN_START SHALL:
- latch the test point;
- set all distances to all-ones, all indices to 0, FILL to 0, the index counter to 0 and OVF to 0;
- clear DONE;
- go to RUN on the next edge.
REQ-019 KNN_START in RUN or DRAIN SHALL be ignored.
REQ-020 KNN_DP_READY SHALL be 1 only in RUN.
REQ-021 A data point is accepted on an edge where VALID and READY are both 1.
REQ-022 The index counter SHALL increment once per accepted point; the first accepted point gets index 0.
REQ-023 Gaps in VALID SHALL be allowed and SHALL NOT affect the result.
REQ-024 Distance SHALL be |KNN_DP - test point|:
- unsigned, DATA_W bits, no overflow;
- registered one cycle after acceptance (stage 1).
REQ-025 Insertion (stage 2) SHALL place the new entry before the first entry whose distance is strictly greater and shift later entries down; entry K-1 is discarded.
REQ-026 Ties SHALL keep the earlier index first.
REQ-027 If FILL = K and the new distance is >= entry K-1, the list SHALL be unchanged.
REQ-028 FILL SHALL increment on each insertion while FILL < K and saturate at K.
REQ-029 Accepting a point with LAST=1 SHALL move the FSM RUN->DRAIN; READY drops in the same cycle.
REQ-030 DRAIN SHALL last 2 cycles, then the FSM SHALL enter DONE.
REQ-031 KNN_DONE SHALL be 1 in DONE only; the outputs SHALL then be final and stable until the next KNN_START.
REQ-032 An accepted point whose index counter has wrapped past 2^IDX_W-1 SHALL set OVF; the point SHALL still be inserted, with the wrapped index.
REQ-033 The outputs SHALL reflect the live list continuously; consumers SHALL read them only while DONE=1.

Reset
REQ-034 Asserting RST_CORE low at any time, including mid-query, SHALL immediately give:
- FSM IDLE;
- READY, DONE, OVF and FILL = 0;
- all distances all-ones, all indices 0;
- pipeline stages invalid.
REQ-035 After reset release, the core SHALL require a KNN_START before accepting points.

Structure
REQ-036 Package knn_pkg SHALL hold the FSM state encoding, the DRAIN_CYCLES=2 constant and a clog2 function.
REQ-037 The sorted list SHALL be one sub-module, knn_insert_list, with parameters K, DATA_W and IDX_W and ports clear, ins_valid, ins_dist, ins_idx, the list outputs and fill.
REQ-038 The FSM, the index counter and the distance stage SHALL reside in knn_core_param.

Verification (K=6, DATA_W=32, IDX_W=8)
REQ-039 Basic sort: test=100, points 90,105,130,99,100,250,0,101 with LAST on 101.
- Required: DIST 0,1,1,5,10,30; IDX 4,3,7,1,0,2; FILL=6.
- Required: DONE exactly 2 cycles after the LAST handshake.
REQ-040 Under-fill: test=7, points 7,9,3 with LAST on 3.
- Required: DIST 0,2,4 then three all-ones entries; IDX 0,1,2,0,0,0; FILL=3.
REQ-041 Backpressure and gaps: the REQ-039 sequence with VALID randomly deasserted.
- Required: identical result; no point lost or duplicated.
REQ-042 START ignored: a KNN_START with test=0 in mid-RUN.
- Required: no effect; the result matches the original test point.
REQ-043 Reset mid-query: RST_CORE low after 3 points, then a fresh query with REQ-040 stimulus.
- Required: all outputs at reset values; the fresh query gives the REQ-040 result.
REQ-044 Overflow: 257 points all equal to the test point.
- Required: OVF=1; DIST all 0; IDX 0,1,2,3,4,5.
